wishbone_1mst_to_nslv_reg: RTL
==============================

Name: wishbone_1mst_to_nslv_reg

Overview:
- Parametrised successor to the fixed 1-master/8-slave Wishbone splitter.
- Decodes the slave count and the address windows from parameters.
- Registers every request and response, adding one pipeline stage so the bus timing closes at the top level.
- Adds a bus-error path for unmapped addresses and a per-access timeout watchdog, so a hung or missing peripheral can no longer stall the management SoC.

Parameters:
- NB_SLV, 8, number of slave ports (1..16).
- BASE_ADDR, {NB_SLV{32'h30000000 + i*32'h10000}}, packed NB_SLV*32 base addresses; slave i uses bits [32*i+31:32*i].
- ADDR_MASK, {NB_SLV{32'hFFFF0000}}, packed NB_SLV*32 masks; slave i matches when (adr & mask_i) == (base_i & mask_i).
- TO_WIDTH, 8, width of the timeout counter.
- TIMEOUT, 255, cycles in ACCESS before abort; 0 disables the watchdog.
- UNMAPPED_ERR, 1, 1: unmapped access returns err; 0: returns ack with DEFAULT_DATA.
- DEFAULT_DATA, 32'hDEADBEEF, read data for unmapped, timed-out or errored accesses.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_m_cyc_i  in  1  master cycle
- wbs_m_stb_i  in  1  master strobe
- wbs_m_we_i  in  1  master write enable
- wbs_m_sel_i  in  4  master byte select
- wbs_m_adr_i  in  32  master address
- wbs_m_dat_i  in  32  master write data
- wbs_m_dat_o  out  32  read data to master (registered)
- wbs_m_ack_o  out  1  ack to master (registered)
- wbs_m_err_o  out  1  bus error to master (registered)
- wbs_s_cyc_o  out  NB_SLV  per-slave cycle
- wbs_s_stb_o  out  NB_SLV  per-slave strobe
- wbs_s_we_o  out  1  shared write enable
- wbs_s_sel_o  out  4  shared byte select
- wbs_s_adr_o  out  32  shared address
- wbs_s_dat_o  out  32  shared write data
- wbs_s_dat_i  in  NB_SLV*32  packed slave read data
- wbs_s_ack_i  in  NB_SLV  per-slave ack
- timeout_o  out  1  one-cycle pulse on watchdog abort
- err_adr_o  out  32  address of the last errored access

Behaviour:
- Reset: state IDLE. Outputs wbs_m_ack_o, wbs_m_err_o, wbs_s_cyc_o, wbs_s_stb_o, wbs_s_we_o and timeout_o are 0. Outputs wbs_m_dat_o, wbs_s_adr_o, wbs_s_dat_o, wbs_s_sel_o and err_adr_o are 0. Timeout counter is 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On wbs_m_cyc_i & wbs_m_stb_i, latch adr, dat, sel and we into the wbs_s_* registers.
  - Decode the address; if several windows match, the lowest index wins.
  - Hit: assert cyc/stb on the selected slave only, clear the counter, go to ACCESS.
  - Miss: go to RESP with err = UNMAPPED_ERR, dat = DEFAULT_DATA, err_adr_o = adr.
- ACCESS:
  - Counter increments each cycle.
  - On wbs_s_ack_i[sel]: capture wbs_s_dat_i[sel] into wbs_m_dat_o, drop slave cyc/stb, go to RESP with err = 0.
  - If the counter reaches TIMEOUT-1 with no ack (TIMEOUT != 0): drop slave cyc/stb, pulse timeout_o, go to RESP with err = 1, dat = DEFAULT_DATA, err_adr_o = latched adr.
  - Ack and timeout in the same cycle: the ack wins.
  - Acks from unselected slaves are ignored.
- RESP: assert exactly one of wbs_m_ack_o / wbs_m_err_o for one cycle, then go to IDLE.
  - IDLE does not sample a new request in the cycle RESP is exited into, so a back-to-back request is accepted one cycle after the ack.
- Abort: if wbs_m_cyc_i falls while in ACCESS, drop slave cyc/stb and go to IDLE with no ack/err. If it falls while in RESP, finish the one-cycle RESP normally.
- Latency: stb sampled at edge N; slave stb visible after N; a combinational slave ack yields master ack after N+2. Minimum request-to-request spacing is 4 cycles.
- Reset asserted mid-access: everything returns to reset values immediately; no ack is generated.
- wbs_m_dat_o holds its value outside RESP.
- Write accesses: wbs_m_dat_o = slave data on a normal ack (don't-care), DEFAULT_DATA on err.

Test Plan:
- Read 0x30020004, slave 2 acks after 3 cycles with 0x12345678 -> master ack exactly 1 cycle with dat 0x12345678; only wbs_s_stb_o[2] was ever high; no err.
- Write 0x30040000, data 0xA5A5A5A5, sel 4'b0011 -> slave 4 sees adr/dat/sel/we=1 unchanged; master ack after slave ack +1 cycle.
- Read 0x30100000 (unmapped), UNMAPPED_ERR=1 -> no slave stb; err 1 cycle, 2 cycles after request; dat 0xDEADBEEF; err_adr_o 0x30100000.
- TIMEOUT=16, slave 1 never acks -> slave stb high exactly 16 cycles; timeout_o pulse; master err; err_adr_o latched.
- Slave 3 acks on the same cycle the counter hits TIMEOUT-1 -> master ack (not err); no timeout_o pulse.
- Master drops cyc at cycle 2 of ACCESS, then wb_rst_i is pulsed during a later ACCESS -> no ack/err in either case; all slave stb go low at once; next request is served normally.

Source files
------------

// File: rtl/wishbone_1mst_to_nslv_reg_if.sv
// Wishbone bus bundle for the 1-master / N-slave registered splitter.
// The splitter uses the slave modport. The environment, meaning the upstream
// master plus the peripheral slaves, uses the master modport.
interface wishbone_1mst_to_nslv_reg_if #(
  parameter int NB_SLV = 8
);
  // upstream master side
  logic                   wbs_m_cyc_i;
  logic                   wbs_m_stb_i;
  logic                   wbs_m_we_i;
  logic [3:0]             wbs_m_sel_i;
  logic [31:0]            wbs_m_adr_i;
  logic [31:0]            wbs_m_dat_i;
  logic [31:0]            wbs_m_dat_o;
  logic                   wbs_m_ack_o;
  logic                   wbs_m_err_o;
  // downstream slave side
  logic [NB_SLV-1:0]      wbs_s_cyc_o;
  logic [NB_SLV-1:0]      wbs_s_stb_o;
  logic                   wbs_s_we_o;
  logic [3:0]             wbs_s_sel_o;
  logic [31:0]            wbs_s_adr_o;
  logic [31:0]            wbs_s_dat_o;
  logic [NB_SLV*32-1:0]   wbs_s_dat_i;
  logic [NB_SLV-1:0]      wbs_s_ack_i;

  modport slave (
    input  wbs_m_cyc_i, wbs_m_stb_i, wbs_m_we_i, wbs_m_sel_i, wbs_m_adr_i, wbs_m_dat_i,
    output wbs_m_dat_o, wbs_m_ack_o, wbs_m_err_o,
    output wbs_s_cyc_o, wbs_s_stb_o, wbs_s_we_o, wbs_s_sel_o, wbs_s_adr_o, wbs_s_dat_o,
    input  wbs_s_dat_i, wbs_s_ack_i
  );

  modport master (
    output wbs_m_cyc_i, wbs_m_stb_i, wbs_m_we_i, wbs_m_sel_i, wbs_m_adr_i, wbs_m_dat_i,
    input  wbs_m_dat_o, wbs_m_ack_o, wbs_m_err_o,
    input  wbs_s_cyc_o, wbs_s_stb_o, wbs_s_we_o, wbs_s_sel_o, wbs_s_adr_o, wbs_s_dat_o,
    output wbs_s_dat_i, wbs_s_ack_i
  );
endinterface

// File: rtl/wishbone_1mst_to_nslv_reg.sv
// Registered Wishbone 1-master to N-slave splitter.
// Address windows come from parameters. Unmapped addresses get a bus error,
// and a per-access watchdog aborts accesses to a peripheral that never acks.
module wishbone_1mst_to_nslv_reg #(
  parameter int NB_SLV = 8,
  localparam logic [511:0] BASE_DEF = {
    32'h300F0000, 32'h300E0000, 32'h300D0000, 32'h300C0000,
    32'h300B0000, 32'h300A0000, 32'h30090000, 32'h30080000,
    32'h30070000, 32'h30060000, 32'h30050000, 32'h30040000,
    32'h30030000, 32'h30020000, 32'h30010000, 32'h30000000},
  parameter logic [NB_SLV*32-1:0] BASE_ADDR    = BASE_DEF[NB_SLV*32-1:0],
  parameter logic [NB_SLV*32-1:0] ADDR_MASK    = {NB_SLV{32'hFFFF0000}},
  parameter int                   TO_WIDTH     = 8,
  parameter int                   TIMEOUT      = 255,
  parameter bit                   UNMAPPED_ERR = 1'b1,
  parameter logic [31:0]          DEFAULT_DATA = 32'hDEADBEEF
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  wishbone_1mst_to_nslv_reg_if.slave         bus,
  output logic                               timeout_o,
  output logic [31:0]                        err_adr_o
);

  localparam int IDX_W = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [TO_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]    sel_idx;
  logic                resp_err;
  logic [31:0]         resp_dat;
  // Set while leaving RESP. The master still presents the finished
  // request's strobe during that cycle, so IDLE must not sample it.
  logic                skip;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [NB_SLV-1:0]   hit_vec;

  // Address decode; scanning from the top leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NB_SLV - 1; i >= 0; i--) begin
      if ((bus.wbs_m_adr_i & ADDR_MASK[32*i +: 32]) ==
          (BASE_ADDR[32*i +: 32] & ADDR_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    hit_vec = NB_SLV'(1) << hit_idx;
  end

  // Request/response FSM; every bus output is a register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      sel_idx         <= '0;
      resp_err        <= 1'b0;
      resp_dat        <= '0;
      skip            <= 1'b0;
      bus.wbs_m_dat_o <= '0;
      bus.wbs_m_ack_o <= 1'b0;
      bus.wbs_m_err_o <= 1'b0;
      bus.wbs_s_cyc_o <= '0;
      bus.wbs_s_stb_o <= '0;
      bus.wbs_s_we_o  <= 1'b0;
      bus.wbs_s_sel_o <= '0;
      bus.wbs_s_adr_o <= '0;
      bus.wbs_s_dat_o <= '0;
      timeout_o       <= 1'b0;
      err_adr_o       <= '0;
    end else begin
      bus.wbs_m_ack_o <= 1'b0;
      bus.wbs_m_err_o <= 1'b0;
      timeout_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (bus.wbs_m_cyc_i && bus.wbs_m_stb_i) begin
            bus.wbs_s_adr_o <= bus.wbs_m_adr_i;
            bus.wbs_s_dat_o <= bus.wbs_m_dat_i;
            bus.wbs_s_sel_o <= bus.wbs_m_sel_i;
            bus.wbs_s_we_o  <= bus.wbs_m_we_i;
            if (hit) begin
              bus.wbs_s_cyc_o <= hit_vec;
              bus.wbs_s_stb_o <= hit_vec;
              sel_idx         <= hit_idx;
              cnt             <= '0;
              state           <= ACCESS;
            end else begin
              resp_err  <= UNMAPPED_ERR;
              resp_dat  <= DEFAULT_DATA;
              err_adr_o <= bus.wbs_m_adr_i;
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          if (!bus.wbs_m_cyc_i) begin
            // Master gave up: release the slave silently.
            bus.wbs_s_cyc_o <= '0;
            bus.wbs_s_stb_o <= '0;
            state           <= IDLE;
          end else if (bus.wbs_s_ack_i[sel_idx]) begin
            // A late ack still beats the watchdog in the same cycle.
            resp_dat        <= bus.wbs_s_dat_i[32*sel_idx +: 32];
            resp_err        <= 1'b0;
            bus.wbs_s_cyc_o <= '0;
            bus.wbs_s_stb_o <= '0;
            state           <= RESP;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            resp_dat        <= DEFAULT_DATA;
            resp_err        <= 1'b1;
            err_adr_o       <= bus.wbs_s_adr_o;
            timeout_o       <= 1'b1;
            bus.wbs_s_cyc_o <= '0;
            bus.wbs_s_stb_o <= '0;
            state           <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          bus.wbs_m_dat_o <= resp_dat;
          bus.wbs_m_ack_o <= ~resp_err;
          bus.wbs_m_err_o <= resp_err;
          skip            <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
